// File: rtl/lsu_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_subword_ctrl
// Brief    : Load/store unit in front of a word-wide data RAM. Sub-word
//            stores become a read-modify-write pair. Loads are sign- or
//            zero-extended and returned on a registered response channel.
// Options  : LSU_ALIGN_CHECK_EN - when defined, misaligned halfword and word
//            accesses are reported as errors and never touch the RAM.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_subword_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_memwrite,
  input  logic [DATA_W-1:0] ram_read_data
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_ERR    = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   old_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                w_req_bad;
  logic [DATA_W-1:0]   w_load_ext;
  logic [DATA_W-1:0]   w_merge;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic                w_accept;

  // Address bits above the RAM range are deliberately ignored (wrap-around).
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign w_accept       = req_valid & req_ready;
  assign ram_address    = addr_q[ADDR_W+1:2];
  assign ram_write_data = w_merge;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

  // Classify an incoming request as illegal (bad funct3, optionally misaligned).
  always_comb begin
    w_req_bad = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: w_req_bad = 1'b0;
      F3_BU, F3_HU:     w_req_bad = req_we;   // unsigned forms exist only for loads
      default:          w_req_bad = 1'b1;
    endcase
`ifdef LSU_ALIGN_CHECK_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      w_req_bad = 1'b1;
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
      w_req_bad = 1'b1;
`endif
  end

  // Lane select and extension of the RAM read word for loads.
  always_comb begin
    w_byte     = ram_read_data[{addr_q[1:0], 3'b000} +: 8];
    w_half     = ram_read_data[{addr_q[1], 4'b0000} +: 16];
    w_load_ext = ram_read_data;
    case (funct3_q)
      F3_B:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load_ext = {24'd0, w_byte};
      F3_HU:   w_load_ext = {16'd0, w_half};
      default: w_load_ext = ram_read_data;
    endcase
  end

  // Write word: old word with the addressed lane replaced, or the full store data.
  always_comb begin
    w_merge = old_q;
    case (funct3_q)
      F3_B:    w_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      F3_H:    w_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: w_merge = wdata_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs; RAM write enable depends only on state.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ram_memwrite = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_bad)                state_d = S_ERR;
          else if (!req_we)             state_d = S_LOAD;
          else if (req_funct3 == F3_W)  state_d = S_WRITE;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE: begin
        ram_memwrite = 1'b1;
        state_d      = S_RESP;
      end
      S_ERR:    state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, RMW old-word capture and response data/error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (w_accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_W+1:0];
        wdata_q  <= req_wdata;
        if (w_req_bad) err_q <= 1'b1;
      end
      case (state_q)
        S_LOAD:   rdata_q <= w_load_ext;
        S_RMW_RD: old_q   <= ram_read_data;
        S_WRITE:  rdata_q <= '0;
        S_ERR:    rdata_q <= '0;
        S_RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_subword_ctrl
// Brief    : Self-checking bench for lsu_subword_ctrl with a word RAM model
//            and a behavioural reference memory. Honours LSU_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_subword_ctrl;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_write_data;
  logic              ram_memwrite;
  logic [31:0]       ram_read_data;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  int          mw_total = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  lsu_subword_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_memwrite   (ram_memwrite),
    .ram_read_data  (ram_read_data)
  );

  always #5 clk = ~clk;

  // Word RAM: combinational read, write on the falling edge.
  assign ram_read_data = mem[ram_address];
  always @(negedge clk) begin
    if (ram_memwrite === 1'b1) begin
      mem[ram_address] = ram_write_data;
      mw_total++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction checked against the reference model.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd, w, v, neww;
    int          idx, off, sh, exp_lat, exp_nwr, lat, mw0;

    idx     = int'((a >> 2) % WORDS);
    off     = int'(a % 4);
    w       = ref_mem[idx];
    exp_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
`ifdef LSU_ALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) == 1) exp_err = 1'b1;
    if (f3 == 3'd2 && off != 0) exp_err = 1'b1;
`endif
    exp_rd = 32'd0;
    neww   = w;
    if (!exp_err && !we) begin
      case (f3)
        3'd0, 3'd4: begin
          v      = (w >> (8 * off)) & 32'd255;
          exp_rd = (f3 == 3'd0 && v >= 32'd128) ? v - 32'd256 : v;
        end
        3'd1, 3'd5: begin
          v      = (w >> (16 * (off / 2))) & 32'd65535;
          exp_rd = (f3 == 3'd1 && v >= 32'd32768) ? v - 32'd65536 : v;
        end
        default: exp_rd = w;
      endcase
    end
    if (!exp_err && we) begin
      case (f3)
        3'd0: begin
          sh   = 8 * off;
          neww = (w & ~(32'd255 << sh)) | ((wd & 32'd255) << sh);
        end
        3'd1: begin
          sh   = 16 * (off / 2);
          neww = (w & ~(32'd65535 << sh)) | ((wd & 32'd65535) << sh);
        end
        default: neww = wd;
      endcase
    end
    exp_lat = (we && !exp_err && f3 != 3'd2) ? 3 : 2;
    exp_nwr = (we && !exp_err) ? 1 : 0;

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    mw0        = mw_total;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    got_rd  = resp_rdata;
    got_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", 32'(resp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_err", 32'(resp_err), 32'd0);
    chk("memwrite_cycles", 32'(mw_total - mw0), 32'(exp_nwr));
    if (exp_nwr == 1) ref_mem[idx] = neww;
    chk("ram_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_memwrite"}, 32'(ram_memwrite), 32'd0);
    chk({tag, "_address"}, 32'(ram_address), 32'd0);
    chk({tag, "_write_data"}, ram_write_data, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra, rw;
    logic [2:0]  rf;
    logic        rwe;

    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[4]     = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    // Reset state
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Byte loads, signed and unsigned
    txn(1'b0, 3'b000, 32'h12, 32'd0, 0, rd, er);
    chk("lb_0x12", rd, 32'hFFFFFF99);
    txn(1'b0, 3'b100, 32'h12, 32'd0, 0, rd, er);
    chk("lbu_0x12", rd, 32'h00000099);

    // Sub-word store through read-modify-write
    txn(1'b1, 3'b000, 32'h11, 32'h000000C3, 0, rd, er);
    chk("sb_word4", mem[4], 32'h8899C3BB);

    // Word store then halfword loads
    txn(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0, rd, er);
    txn(1'b0, 3'b101, 32'h22, 32'd0, 0, rd, er);
    chk("lhu_0x22", rd, 32'h0000DEAD);
    txn(1'b0, 3'b001, 32'h20, 32'd0, 0, rd, er);
    chk("lh_0x20", rd, 32'hFFFFBEEF);

    // Misaligned halfword load
    txn(1'b0, 3'b001, 32'h13, 32'd0, 0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lh_0x13_err", 32'(er), 32'd1);
    chk("lh_0x13_rdata", rd, 32'd0);
`else
    chk("lh_0x13_err", 32'(er), 32'd0);
    chk("lh_0x13_rdata", rd, 32'hFFFF8899);
`endif

    // Invalid store funct3 with response backpressure
    txn(1'b1, 3'b100, 32'h10, 32'h12345678, 5, rd, er);
    chk("sbu_err", 32'(er), 32'd1);
    chk("sbu_word4", mem[4], 32'h8899C3BB);

    // Reset during RMW_RD of a byte store
    mem[4]     = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h11;
    req_wdata  = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_word4", mem[4], 32'h8899AABB);

    // Randomized traffic over a small window with random high address bits
    for (int n = 0; n < 48; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rf  = 3'($urandom_range(0, 7));
      ra  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 47));
      rw  = $urandom;
      txn(rwe, rf, ra, rw, int'($urandom_range(0, 2)), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
- Load/store unit that sits directly upstream of the word-wide data RAM (32-bit words, write on clk negedge, combinational read).
- Accepts byte, halfword and word requests from the RISC-V core over a valid/ready handshake.
- Sub-word stores become a read-modify-write pair, because the RAM has only a full-word write enable.
- Load data is sign- or zero-extended and returned on a registered response channel.

Parameters:
- ADDR_W, 10, RAM word-address width (1024 words).
- DATA_W, 32, data width; fixed at 32 and not overridable in practice.

Ports:
- clk  in  1  system clock; all LSU state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  bad funct3, or misaligned access when alignment checking is compiled in.
- ram_address  out  ADDR_W  word address, equal to the registered byte address bits [ADDR_W+1:2].
- ram_write_data  out  32  merged write word.
- ram_memwrite  out  1  RAM write enable.
- ram_read_data  in  32  RAM combinational read data.

Behaviour:
- Reset values (asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_memwrite=0, ram_address=0, ram_write_data=0.
- Request register: on accept (req_valid & req_ready at a posedge), latch req_we, req_funct3, req_addr and req_wdata. ram_address is driven from this latched address only.
- State IDLE:
  - On accept with invalid funct3 (011, 110, 111, or 100/101 with req_we=1) -> ERR.
  - Load -> LOAD.
  - Word store -> WRITE.
  - Byte/halfword store -> RMW_RD.
- State LOAD (1 cycle): at the posedge, capture ram_read_data, select the lane, extend it, store into resp_rdata -> RESP.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Funct3 000/001 sign-extend; 100/101 zero-extend.
- State RMW_RD (1 cycle): capture ram_read_data into the old-word register -> WRITE.
- State WRITE (1 cycle): ram_memwrite=1 for the whole cycle, so the RAM commits at the mid-cycle negedge -> RESP.
  - ram_write_data = old word with the selected byte/halfword lane replaced by the low bits of the latched wdata.
  - For a word store, ram_write_data = latched wdata.
- State ERR: resp_err=1, resp_rdata=0 -> RESP. No RAM write occurs on any error path.
- State RESP: resp_valid=1. resp_rdata and resp_err stay stable while resp_ready=0. When resp_ready=1 at a posedge -> IDLE, resp_valid=0, resp_err=0.
- Latency (accept edge to resp_valid):
  - Load: 2 posedges.
  - Word store: 2 posedges.
  - Sub-word store: 3 posedges.
  - Error: 2 posedges.
- Back-to-back: no new request is accepted in the same cycle as a response handshake; the next accept earliest happens in the IDLE cycle that follows.
- ram_memwrite is a decode of the registered state only; it is never combinational from core inputs.
- Reset mid-operation: asserting reset in RMW_RD or WRITE before the negedge suppresses the write; memory keeps its old word.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Halfword with addr[0]=1 -> ERR; no RAM access.
  - Word with addr[1:0]!=00 -> ERR; no RAM access.
- Undefined:
  - Misalignment is never an error.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - Access proceeds on the truncated alignment.
- Invalid-funct3 errors are reported in both builds.

Test Plan:
1. Preload word 4 = 0x8899AABB. LB at addr 0x12 -> resp_rdata 0xFFFFFF99, resp_err 0. LBU at 0x12 -> 0x00000099. resp_valid 2 posedges after accept in both cases.
2. SB wdata 0x000000C3 to addr 0x11, word 4 = 0x8899AABB -> RAM word 4 = 0x8899C3BB. ram_memwrite high for exactly one cycle; response after 3 posedges.
3. SW 0xDEADBEEF to 0x20, then LHU at 0x22 -> 0x0000DEAD; LH at 0x20 -> 0xFFFFBEEF.
4. LH at 0x13:
   - With LSU_ALIGN_CHECK_EN: resp_err 1, resp_rdata 0, no RAM write.
   - Without it: resp_rdata = sign-extended upper halfword of word 4 (0xFFFF8899).
5. Invalid funct3 cases, and response backpressure:
   - Store with funct3=100 -> resp_err 1; RAM unchanged.
   - Hold resp_ready=0 for 5 cycles: resp_valid and resp_err stay stable, req_ready=0 throughout.
6. Reset mid-RMW: assert reset during RMW_RD of an SB to 0x11 -> word 4 stays 0x8899AABB. All outputs return to reset values immediately.
